// File: rtl/fetch_buffer_if.sv
// Instruction-memory port plus core-side fetch handshake of the fetch buffer.
// master = fetch_buffer side; slave = memory/core environment side.
interface fetch_buffer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic [ADDR_W-1:0]  MemEndereco;
  logic               MemLeitura;
  logic [INSTR_W-1:0] MemInstrucao;
  logic               Redirect;
  logic [ADDR_W-1:0]  RedirectPC;
  logic               InstrValid;
  logic [INSTR_W-1:0] Instrucao;
  logic [ADDR_W-1:0]  InstrPC;
  logic               InstrReady;
  logic               Halt;

  modport master (
    output MemEndereco, MemLeitura, InstrValid, Instrucao, InstrPC, Halt,
    input  MemInstrucao, Redirect, RedirectPC, InstrReady
  );

  modport slave (
    input  MemEndereco, MemLeitura, InstrValid, Instrucao, InstrPC, Halt,
    output MemInstrucao, Redirect, RedirectPC, InstrReady
  );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch front end: own PC, one synchronous read per cycle, tagged FIFO to the core, halt/redirect.
// Issue N, push N+1, InstrValid N+2; InstrReady=0 stalls issue once count+inflight reaches DEPTH.
module fetch_buffer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = '0
) (
  input logic            Clock,
  input logic            Reset,
  fetch_buffer_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  entry_t             fifoMem [DEPTH];
  entry_t             headEntry;
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;
  logic [ADDR_W-1:0]  fetchPC;
  logic [ADDR_W-1:0]  lastAddr;
  logic [ADDR_W-1:0]  tag;
  logic               inflight;
  logic               haltSeen;
  logic               haltReg;
  logic               issue;
  logic               push;
  logic               pop;
  logic               headValid;

  // Credit uses registered count/inflight only, so a same-cycle pop frees nothing.
  always_comb begin
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    headValid = (count != '0);
    headEntry = fifoMem[rdPtr];
    issue     = !Reset && !haltSeen && !bus.Redirect && (occupancy < DEPTH_LIM);
    push      = !Reset && !bus.Redirect && inflight && !haltSeen;
    pop       = !Reset && !bus.Redirect && headValid && bus.InstrReady;
  end

  assign bus.MemLeitura  = issue;
  assign bus.MemEndereco = issue ? fetchPC : lastAddr;
  assign bus.InstrValid  = headValid;
  assign bus.Instrucao   = headValid ? headEntry.instr : '0;
  assign bus.InstrPC     = headValid ? headEntry.pc : '0;
  assign bus.Halt        = haltReg;

  always_ff @(posedge Clock) begin
    if (push) begin
      fifoMem[wrPtr] <= '{instr: bus.MemInstrucao, pc: tag};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetchPC  <= '0;
      lastAddr <= '0;
      tag      <= '0;
      inflight <= 1'b0;
      haltSeen <= 1'b0;
      haltReg  <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
    end else if (bus.Redirect) begin
      // Flush: buffered entries and the outstanding read are abandoned.
      fetchPC  <= bus.RedirectPC;
      inflight <= 1'b0;
      haltSeen <= 1'b0;
      haltReg  <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetchPC  <= fetchPC + ADDR_W'(1);
        lastAddr <= fetchPC;
        tag      <= fetchPC;
      end
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (push && (bus.MemInstrucao == HALT_OPCODE)) begin
        haltSeen <= 1'b1;
      end
      if (pop && (headEntry.instr == HALT_OPCODE)) begin
        haltReg <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed cycle checks plus randomized traffic against a program-order
// model (sequential PCs from the restart point up to and including the first halt byte).
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam logic [7:0] HALT = 8'h00;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] pc;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  fetch_buffer_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

  fetch_buffer #(
    .DEPTH(DEPTH), .ADDR_W(8), .INSTR_W(8), .HALT_OPCODE(HALT)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus.master)
  );

  always #5 Clock = ~Clock;

  // Instruction memory: 256 x 8, data valid the cycle after the read is issued.
  logic [7:0] mem [256];
  logic [7:0] memQ = 8'h00;
  always @(posedge Clock) if (bus.MemLeitura === 1'b1) memQ <= mem[bus.MemEndereco];
  assign bus.MemInstrucao = memQ;

  int   compared = 0;
  int   mismatched = 0;
  exp_t expQ[$];
  bit   started = 0;
  bit   modelHalt = 0;
  int   tbOut = 0;
  bit   prevStall = 0;
  logic [7:0] prevInstr = 8'h00;
  logic [7:0] prevPC = 8'h00;
  int   noProg = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, want);
    end
  endtask

  // Expected delivery stream after a restart at 'start'.
  task automatic rebuild(input logic [7:0] start);
    logic [7:0] pc;
    expQ.delete();
    pc = start;
    for (int i = 0; i < 1024; i++) begin
      expQ.push_back('{instr: mem[pc], pc: pc});
      if (mem[pc] == HALT) break;
      pc = pc + 8'd1;
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic redir, input logic [7:0] rpc);
    @(posedge Clock);
    #1;
    Reset = rst;
    bus.InstrReady = rdy;
    bus.Redirect = redir;
    bus.RedirectPC = rpc;
    if (rst) rebuild(8'h00);
    else if (redir) rebuild(rpc);
  endtask

  always @(negedge Clock) begin : monitor
    logic hs;
    bit   popHalt;
    exp_t e;
    popHalt = 0;
    hs = !Reset && !bus.Redirect && bus.InstrValid && bus.InstrReady;
    if (started) begin
      check("halt_out", bus.Halt, modelHalt);
      if (bus.MemLeitura) check("issue_credit", tbOut < DEPTH, 1);
      if (bus.Redirect) check("no_issue_on_redirect", bus.MemLeitura, 0);
      if (modelHalt) check("no_issue_after_halt", bus.MemLeitura, 0);
      if (prevStall) check("head_stable", {bus.InstrValid, bus.Instrucao, bus.InstrPC},
                           {1'b1, prevInstr, prevPC});
      if (hs) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL extra_delivery at %0t: got pc 0x%0h, expected no delivery", $time, bus.InstrPC);
        end else begin
          e = expQ.pop_front();
          check("deliver", {bus.Instrucao, bus.InstrPC}, e);
          popHalt = (e.instr == HALT);
        end
      end
      if (!Reset && !bus.Redirect && bus.InstrReady && expQ.size() > 0 && !hs) noProg++;
      else noProg = 0;
      if (noProg > 8) begin
        compared++;
        mismatched++;
        $display("FAIL liveness at %0t: got no delivery for %0d ready cycles, expected pc 0x%0h",
                 $time, noProg, expQ[0].pc);
        noProg = 0;
      end
    end
    if (Reset || bus.Redirect) begin
      modelHalt = 0;
      tbOut = 0;
    end else begin
      if (popHalt) modelHalt = 1;
      tbOut = tbOut + int'(bus.MemLeitura) - int'(hs);
    end
    prevStall = started && !Reset && !bus.Redirect && bus.InstrValid && !bus.InstrReady;
    prevInstr = bus.Instrucao;
    prevPC = bus.InstrPC;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, bus.MemEndereco, 0);
    check({tag, "_valid"}, bus.InstrValid, 0);
    check({tag, "_instr"}, bus.Instrucao, 0);
    check({tag, "_pc"}, bus.InstrPC, 0);
    check({tag, "_halt"}, bus.Halt, 0);
  endtask

  initial begin
    logic       rst, rdy, redir, expV;
    logic [7:0] rpc, expPC;

    bus.InstrReady = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectPC = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h55;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h00; mem[4] = 8'h55;

    // Reset state
    drive(1, 0, 0, 0);
    started = 1;
    @(negedge Clock);
    check_reset_outputs("rst");
    check("rst_issue", bus.MemLeitura, 0);

    // Stream then halt
    for (int c = 0; c < 9; c++) begin
      drive(0, 1, 0, 0);
      @(negedge Clock);
      check("A_issue", bus.MemLeitura, c <= 4);
      check("A_addr", bus.MemEndereco, (c <= 4) ? c : 4);
      check("A_valid", bus.InstrValid, c >= 2 && c <= 5);
      if (c >= 2 && c <= 5) check("A_head", {bus.Instrucao, bus.InstrPC}, {mem[c-2], 8'(c-2)});
      check("A_halt", bus.Halt, c >= 6);
    end

    // Reset while halted, then backpressure from reset
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h80);
    drive(1, 0, 0, 0);
    @(negedge Clock);
    check("F_halt_during_reset", bus.Halt, 1);
    for (int c = 0; c < 16; c++) begin
      drive(0, c >= 8, 0, 0);
      @(negedge Clock);
      if (c == 0) check_reset_outputs("F_post");
      check("B_valid", bus.InstrValid, c >= 2);
      if (c < 8) check("B_issue", bus.MemLeitura, c <= 3);
      if (c >= 2) begin
        expPC = (c < 8) ? 8'h00 : 8'(c - 8);
        check("B_head", {bus.Instrucao, bus.InstrPC}, {8'(expPC + 8'h80), expPC});
      end
    end

    // Fill the FIFO, reset with it full, then redirect (0x40) and wrap (0xFE)
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0, 0);
      @(negedge Clock);
    end
    check("E_full_valid", bus.InstrValid, 1);
    check("E_full_noissue", bus.MemLeitura, 0);
    drive(1, 0, 0, 0);
    for (int c = 0; c < 17; c++) begin
      drive(0, 1, c == 5 || c == 10, (c == 5) ? 8'h40 : 8'hFE);
      @(negedge Clock);
      if (c == 0) begin
        check_reset_outputs("E_post");
        check("E_post_issue", bus.MemLeitura, 1);
      end
      expV = (c >= 2 && c <= 5) || (c >= 8 && c <= 10) || c >= 13;
      expPC = (c <= 5) ? 8'(c - 2) : (c <= 10) ? 8'(8'h40 + c - 8) : 8'(8'hFE + c - 13);
      check("C_valid", bus.InstrValid, expV);
      if (expV) check("C_head", {bus.Instrucao, bus.InstrPC}, {8'(expPC + 8'h80), expPC});
      if (c == 5 || c == 10) check("C_redirect_noissue", bus.MemLeitura, 0);
      if (c == 6) check("C_addr40", bus.MemEndereco, 8'h40);
      if (c == 11) check("C_addrFE", bus.MemEndereco, 8'hFE);
    end

    // Randomized traffic
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 31) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      redir = ($urandom_range(0, 24) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 255));
      rdy = ($urandom_range(0, 3) != 0);
      drive(rst, rdy, redir, rpc);
    end
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Instruction-fetch front end between the instruction memory (MemoriaInstrucao: 256 x 8, synchronous read) and the nRisc core. It runs its own fetch PC and issues one read per cycle. Returned bytes are tagged with their address and buffered in a small FIFO. The core receives them over a valid/ready handshake. The block also handles PC redirects (branch or jump flush) and detects the all-zero halt instruction.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
ADDR_W, 8, instruction address width
INSTR_W, 8, instruction width
HALT_OPCODE, 8'b00000000, instruction that ends fetching

Ports:
Clock  input  1  single clock, all logic on rising edge
Reset  input  1  synchronous, active-high; sampled on rising edge of Clock
MemEndereco  output  ADDR_W  address to instruction memory
MemLeitura  output  1  read issued this cycle
MemInstrucao  input  INSTR_W  memory data, valid the cycle after issue
Redirect  input  1  core requests flush and restart
RedirectPC  input  ADDR_W  restart address, sampled when Redirect=1
InstrValid  output  1  FIFO head valid
Instrucao  output  INSTR_W  FIFO head instruction
InstrPC  output  ADDR_W  address of FIFO head instruction
InstrReady  input  1  core accepts head when InstrValid=1
Halt  output  1  halt instruction has been consumed

Behaviour:
- Reset (synchronous, priority over everything):
  - FetchPC=0, FIFO empty, inflight=0, HaltSeen=0.
  - Outputs: MemEndereco=0, MemLeitura=0, InstrValid=0, Instrucao=0, InstrPC=0, Halt=0.
  - Applies identically mid-operation; all buffered and inflight data is discarded.
- Issue (cycle N):
  - MemLeitura=1 iff !HaltSeen && !Redirect && (count + inflight) < DEPTH, using registered count and inflight. A pop in the same cycle gives no credit.
  - When MemLeitura=1, MemEndereco=FetchPC. At the edge, FetchPC <= FetchPC+1 modulo 2^ADDR_W (0xFF wraps to 0x00), inflight <= 1, tag <= FetchPC.
  - When MemLeitura=0, MemEndereco holds its last value.
- Return (cycle N+1):
  - If inflight=1 and no Redirect or Reset in cycle N+1 and HaltSeen=0, push {MemInstrucao, tag} at the edge.
  - If the pushed byte equals HALT_OPCODE, set HaltSeen=1.
  - Any return arriving while HaltSeen=1 is dropped.
- Output:
  - Instrucao, InstrPC and InstrValid come from registered FIFO state (head entry), not combinationally from memory.
  - First instruction after reset release: issued in cycle 0, pushed end of cycle 1, InstrValid=1 in cycle 2.
  - With InstrReady held at 1, throughput is one instruction per cycle.
- Handshake:
  - Pop occurs when InstrValid && InstrReady.
  - Head values stay stable while InstrValid=1 and InstrReady=0.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Push into a full FIFO cannot occur (guaranteed by the issue rule). The verification engineer asserts this.
- Redirect (cycle R, priority below Reset):
  - At the edge: FIFO cleared, inflight cleared (its data in R+1 is dropped), HaltSeen=0, Halt=0, FetchPC <= RedirectPC.
  - A handshake in cycle R is discarded: no pop credit and no Halt set.
  - No issue in cycle R. The RedirectPC read issues in R+1 and its InstrValid appears in R+3.
- Halt:
  - Halt <= 1 on the edge ending the cycle where the HALT_OPCODE entry is popped.
  - Halt stays 1 until Reset or Redirect.
  - No further issues occur after HaltSeen.
- Widths: count is log2(DEPTH)+1 bits. All PC arithmetic is ADDR_W bits, unsigned, wrapping.

Test Plan:
1. Stream: mem[0..2]=0x11,0x22,0x33, InstrReady=1, Reset released cycle 0 -> (0x11,PC 0) cycle 2, (0x22,1) cycle 3, (0x33,2) cycle 4; MemLeitura high every cycle.
2. Backpressure: InstrReady=0 from reset -> MemLeitura drops once count+inflight=4. FIFO holds PCs 0..3 with the head stable. Releasing InstrReady delivers 0,1,2,3,4... with none lost or duplicated.
3. Redirect with inflight: Redirect=1, RedirectPC=0x40 in cycle 5 -> cycle 6 InstrValid=0, the stale return is dropped, and the next delivered InstrPC is 0x40 in cycle 8.
4. Halt: mem[3]=0x00, mem[4]=0x55 -> (0x00,PC 3) is delivered, PC 4 is never delivered, Halt=1 the cycle after its pop, and MemLeitura stays 0 thereafter.
5. Wrap: redirect to 0xFE -> delivered InstrPC sequence 0xFE, 0xFF, 0x00, 0x01.
6. Reset mid-run with a full FIFO and Halt=1 -> next cycle all outputs match reset values, and fetch restarts at PC 0 with InstrValid in cycle 2.
